// File: rtl/alu_flags_buffer.sv
// alu_flags_buffer
//
// Purpose: registered output stage behind the ALU flag logic. Each ALU result
// is captured together with its operation select and its four status flags
// into a two-entry FIFO. The FIFO is drained over a valid/ready handshake.
// The block also keeps sticky overflow/carry bits and a modulo-256 count of
// delivered entries.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid / in_ready     upstream handshake (in_ready = fewer than 2 held)
//   in_result, in_sel       ALU result (N bits) and operation select (4 bits)
//   in_neg/in_z/in_o/in_ca  status flags as produced by the flag stage
//   out_valid / out_ready   downstream handshake for the head entry
//   out_result, out_sel     head entry fields, driven 0 while out_valid = 0
//   out_flags               head flags packed {Neg, Z, O, Ca}
//   sticky_o, sticky_ca     set by any accepted entry carrying O / Ca
//   sticky_clr              clears both sticky bits (a same-cycle set wins)
//   op_count, count_clr     popped-entry counter and its clear
module alu_flags_buffer #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_result,
  input  logic [3:0]   in_sel,
  input  logic         in_neg,
  input  logic         in_z,
  input  logic         in_o,
  input  logic         in_ca,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic [3:0]   out_sel,
  output logic [3:0]   out_flags,
  output logic         sticky_o,
  output logic         sticky_ca,
  input  logic         sticky_clr,
  output logic [7:0]   op_count,
  input  logic         count_clr
);

  // Entry layout: {result, sel, neg, z, o, ca}
  localparam int EW = N + 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [EW-1:0]   r_head;
  logic [EW-1:0]   r_tail;
  logic [EW-1:0]   w_nextHead;
  logic [EW-1:0]   w_nextTail;
  logic [EW-1:0]   w_inEntry;
  logic            w_push;
  logic            w_pop;
  logic            r_stickyO;
  logic            r_stickyCa;
  logic [7:0]      r_opCount;

  // Handshake status depends only on the registered state, so no path
  // exists from out_ready to in_ready.
  assign in_ready  = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);

  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign w_inEntry = {in_result, in_sel, in_neg, in_z, in_o, in_ca};

  // Shift-pair storage: r_head is always the oldest entry. On a pop from
  // FULL the tail moves into the head; on push+pop in ONE the new entry
  // goes straight into the head.
  always_comb begin
    w_nextState = r_state;
    w_nextHead  = r_head;
    w_nextTail  = r_tail;
    case (r_state)
      EMPTY: begin
        if (w_push) begin
          w_nextState = ONE;
          w_nextHead  = w_inEntry;
        end
      end
      ONE: begin
        if (w_push && w_pop) begin
          w_nextHead = w_inEntry;
        end else if (w_push) begin
          w_nextState = FULL;
          w_nextTail  = w_inEntry;
        end else if (w_pop) begin
          w_nextState = EMPTY;
        end
      end
      FULL: begin
        if (w_pop) begin
          w_nextState = ONE;
          w_nextHead  = r_tail;
        end
      end
      default: begin
        w_nextState = EMPTY;
      end
    endcase
  end

  // State and entry registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_state <= w_nextState;
      r_head  <= w_nextHead;
      r_tail  <= w_nextTail;
    end
  end

  // Sticky bits: a set from an accepted entry overrides a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stickyO  <= 1'b0;
      r_stickyCa <= 1'b0;
    end else begin
      r_stickyO  <= (w_push & in_o)  | (r_stickyO  & ~sticky_clr);
      r_stickyCa <= (w_push & in_ca) | (r_stickyCa & ~sticky_clr);
    end
  end

  // Pop counter: clear dominates a same-cycle pop; wraps naturally at 256.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_opCount <= 8'd0;
    end else if (count_clr) begin
      r_opCount <= 8'd0;
    end else if (w_pop) begin
      r_opCount <= r_opCount + 8'd1;
    end
  end

  assign out_result = out_valid ? r_head[EW-1 -: N] : '0;
  assign out_sel    = out_valid ? r_head[7:4]       : 4'd0;
  assign out_flags  = out_valid ? r_head[3:0]       : 4'd0;
  assign sticky_o   = r_stickyO;
  assign sticky_ca  = r_stickyCa;
  assign op_count   = r_opCount;

endmodule

// File: tb/tb_alu_flags_buffer.sv
// tb_alu_flags_buffer
//
// Purpose: self-checking bench for alu_flags_buffer. A queue-based model of
// the buffer runs alongside the DUT and a compare process checks every
// output each cycle; directed sequences add literal expectations, then a
// randomized phase exercises the handshake, sticky bits, counter and reset.
module tb_alu_flags_buffer;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_result;
  logic [3:0]   in_sel;
  logic         in_neg;
  logic         in_z;
  logic         in_o;
  logic         in_ca;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_result;
  logic [3:0]   out_sel;
  logic [3:0]   out_flags;
  logic         sticky_o;
  logic         sticky_ca;
  logic         sticky_clr;
  logic [7:0]   op_count;
  logic         count_clr;

  int total = 0;
  int bad   = 0;
  bit checkEn = 1'b0;

  // Model state: entries kept as {result, sel, flags}.
  logic [N+7:0] mq[$];
  bit           mStickyO;
  bit           mStickyCa;
  int           mCount;

  alu_flags_buffer #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_sel     (in_sel),
    .in_neg     (in_neg),
    .in_z       (in_z),
    .in_o       (in_o),
    .in_ca      (in_ca),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_sel    (out_sel),
    .out_flags  (out_flags),
    .sticky_o   (sticky_o),
    .sticky_ca  (sticky_ca),
    .sticky_clr (sticky_clr),
    .op_count   (op_count),
    .count_clr  (count_clr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model update: a FIFO of depth 2 decides acceptance and delivery from
  // its size before the edge.
  always @(posedge clk) begin
    bit pushOk;
    bit popOk;
    if (!rst_n) begin
      mq.delete();
      mStickyO  = 1'b0;
      mStickyCa = 1'b0;
      mCount    = 0;
    end else begin
      pushOk = in_valid && (mq.size() < 2);
      popOk  = (mq.size() > 0) && out_ready;
      if (sticky_clr) begin
        mStickyO  = 1'b0;
        mStickyCa = 1'b0;
      end
      if (pushOk && in_o)  mStickyO  = 1'b1;
      if (pushOk && in_ca) mStickyCa = 1'b1;
      if (count_clr)   mCount = 0;
      else if (popOk)  mCount = (mCount + 1) % 256;
      if (popOk) void'(mq.pop_front());
      if (pushOk) mq.push_back({in_result, in_sel, in_neg, in_z, in_o, in_ca});
    end
  end

  // Compare process: every output against the model, once per cycle.
  always @(negedge clk) begin
    logic [N+7:0] head;
    if (checkEn) begin
      head = (mq.size() > 0) ? mq[0] : '0;
      checkOutput("in_ready",   32'(in_ready),   32'(mq.size() < 2));
      checkOutput("out_valid",  32'(out_valid),  32'(mq.size() > 0));
      checkOutput("out_result", 32'(out_result), 32'(head[N+7:8]));
      checkOutput("out_sel",    32'(out_sel),    32'(head[7:4]));
      checkOutput("out_flags",  32'(out_flags),  32'(head[3:0]));
      checkOutput("sticky_o",   32'(sticky_o),   32'(mStickyO));
      checkOutput("sticky_ca",  32'(sticky_ca),  32'(mStickyCa));
      checkOutput("op_count",   32'(op_count),   32'(mCount));
    end
  end

  // Drive one cycle of inputs (called at a falling edge), then advance to
  // the next falling edge so outputs reflect the intervening rising edge.
  task automatic applyStimulus(input logic rst, input logic v,
                               input logic [N-1:0] res, input logic [3:0] sel,
                               input logic [3:0] flags, input logic ordy,
                               input logic sclr, input logic cclr);
    rst_n      = rst;
    in_valid   = v;
    in_result  = res;
    in_sel     = sel;
    {in_neg, in_z, in_o, in_ca} = flags;
    out_ready  = ordy;
    sticky_clr = sclr;
    count_clr  = cclr;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, '0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Reset held two cycles with in_valid high, then released idle.
    applyStimulus(1'b0, 1'b1, 5'd9, 4'd3, 4'hF, 1'b0, 1'b0, 1'b0);
    checkEn = 1'b1;
    applyStimulus(1'b0, 1'b1, 5'd9, 4'd3, 4'hF, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst in_ready",  32'(in_ready),  32'd1);
    checkOutput("rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst out_result", 32'(out_result), 32'd0);
    checkOutput("rst out_flags", 32'(out_flags), 32'd0);
    checkOutput("rst op_count",  32'(op_count),  32'd0);
    checkOutput("rst sticky",    32'({sticky_o, sticky_ca}), 32'd0);

    // Single pass.
    applyStimulus(1'b1, 1'b1, 5'b10000, 4'b0000, 4'b1010, 1'b1, 1'b0, 1'b0);
    checkOutput("single out_valid",  32'(out_valid),  32'd1);
    checkOutput("single out_result", 32'(out_result), 32'h10);
    checkOutput("single out_flags",  32'(out_flags),  32'hA);
    applyStimulus(1'b1, 1'b0, '0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("single op_count", 32'(op_count), 32'd1);
    checkOutput("single sticky_o", 32'(sticky_o), 32'd1);
    checkOutput("single drained",  32'(out_valid), 32'd0);

    // Backpressure and FIFO order.
    applyStimulus(1'b1, 1'b0, '0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 5'd3, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd7, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("bp in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 1'b1, 5'd9, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("bp head held", 32'(out_result), 32'd3);
    applyStimulus(1'b1, 1'b0, '0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("bp second", 32'(out_result), 32'd7);
    applyStimulus(1'b1, 1'b0, '0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("bp empty",    32'(out_valid), 32'd0);
    checkOutput("bp op_count", 32'(op_count),  32'd2);

    // Streaming ten results with push and pop in the same cycle.
    applyStimulus(1'b1, 1'b0, '0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, 1'b1, 5'(i), 4'(i), 4'(i), 1'b1, 1'b0, 1'b0);
      checkOutput("stream order", 32'(out_result), 32'(i));
      checkOutput("stream ready", 32'(in_ready), 32'd1);
    end
    applyStimulus(1'b1, 1'b0, '0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("stream op_count", 32'(op_count), 32'd10);

    // Sticky set wins over a same-cycle clear.
    applyStimulus(1'b1, 1'b1, 5'd1, 4'd0, 4'b0001, 1'b1, 1'b1, 1'b0);
    checkOutput("sticky set wins", 32'(sticky_ca), 32'd1);
    applyStimulus(1'b1, 1'b0, '0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("sticky cleared", 32'(sticky_ca), 32'd0);

    // Reset while FULL discards entries.
    applyStimulus(1'b1, 1'b1, 5'd11, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd12, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("full in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b0, 1'b0, '0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("midrst out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst in_ready",  32'(in_ready),  32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, '0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      checkOutput("no stale entry", 32'(out_valid), 32'd0);
    end

    // 256 pops wrap the counter.
    for (int i = 0; i < 256; i++)
      applyStimulus(1'b1, 1'b1, 5'(i), 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("wrap pre", 32'(op_count), 32'd255);
    applyStimulus(1'b1, 1'b0, '0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("wrap op_count", 32'(op_count), 32'd0);

    // Pop together with count_clr.
    applyStimulus(1'b1, 1'b1, 5'd4, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("pre clr count", 32'(op_count), 32'd1);
    applyStimulus(1'b1, 1'b1, 5'd5, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("pop with clr", 32'(op_count), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(99) != 0),
                    $urandom_range(1),
                    5'($urandom),
                    4'($urandom),
                    4'($urandom),
                    ($urandom_range(3) != 0),
                    ($urandom_range(15) == 0),
                    ($urandom_range(31) == 0));
    end

    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_flags_buffer.md
# alu_flags_buffer

Registered output stage sitting directly downstream of the ALU flag-generation logic. It captures each ALU result with its operation select and the four status flags (Neg, Z, O, Ca) into a 2-entry buffer. Results are delivered to the consumer (register file writeback or display driver) over a valid/ready handshake. It also keeps sticky overflow/carry indicators and a count of delivered results.

## Interface
- N, default 5: ALU data width in bits; must be ≥ 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  upstream has a result this cycle.
- in_ready  out  1  buffer can accept; equals (occupancy < 2).
- in_result  in  N  ALU result.
- in_sel  in  4  ALU operation select that produced the result.
- in_neg, in_z, in_o, in_ca  in  1 each  flags from the flag stage.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes the head entry.
- out_result  out  N  head result.
- out_sel  out  4  head operation select.
- out_flags  out  4  head flags packed {Neg, Z, O, Ca}, bit 3 = Neg.
- sticky_o  out  1  an accepted entry had O = 1 since the last clear.
- sticky_ca  out  1  an accepted entry had Ca = 1 since the last clear.
- sticky_clr  in  1  clear both sticky bits.
- op_count  out  8  number of entries popped, modulo 256.
- count_clr  in  1  clear op_count.

## Operation
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Entry content: {result, sel, neg, z, o, ca}, 4 + N + 4 bits.
- Storage is two entry registers used as a 2-deep FIFO (head/tail pointers or a shift pair; either is allowed). Ordering is strictly FIFO.
- Occupancy FSM:
  - EMPTY, no push: stay EMPTY. EMPTY, push: go to ONE.
  - ONE, push only: go to FULL. ONE, pop only: go to EMPTY. ONE, push and pop: stay ONE, new entry becomes head.
  - FULL, pop: go to ONE. FULL, no pop: stay FULL.
  - No push is possible in FULL, because in_ready = 0.
- Status outputs per state:
  - in_ready = 1 in EMPTY and ONE, 0 in FULL. It is a function of the registered state only and never depends on out_ready.
  - out_valid = 1 in ONE and FULL.
- When out_valid = 0, out_result, out_sel and out_flags are driven 0.
- The buffer stores the flags exactly as received. It does not recompute them.
- Sticky bits:
  - On a push with in_o = 1, set sticky_o. On a push with in_ca = 1, set sticky_ca.
  - sticky_clr clears both bits.
  - If a set and sticky_clr occur in the same cycle, the set wins and the bit is 1 after the edge.
  - in_valid without in_ready never sets a sticky bit.
- op_count:
  - Increments by 1 on each pop and wraps from 255 to 0.
  - count_clr forces 0. If a pop occurs in the same cycle as count_clr, the result is 0.
- Upstream must hold in_* stable while in_valid & !in_ready. The block does not check this.

## Timing
- Reset (rst_n = 0 at an edge):
  - State goes to EMPTY.
  - Outputs after reset: in_ready = 1, out_valid = 0, out_result = 0, out_sel = 0, out_flags = 0, sticky_o = 0, sticky_ca = 0, op_count = 0.
  - Reset overrides every other input in the same cycle. Entries already in the buffer are discarded.
- Latency:
  - An entry pushed at edge k is visible with out_valid = 1 immediately after edge k.
  - There is no combinational path from in_* to out_*.
- Throughput: 1 entry per cycle sustained while out_ready = 1.
- out_* change only at clock edges.
- While out_valid = 1 and out_ready = 0, the head entry holds stable.
- Sticky bits and op_count update at the same edge as the push or pop that causes them.

## Test plan
- Reset and idle: hold rst_n = 0 for 2 cycles with in_valid = 1, then release with in_valid = 0. Required: in_ready = 1, out_valid = 0, all out_* = 0, op_count = 0, both sticky bits = 0.
- Single pass (N = 5):
  - Push result 5'b10000, sel 4'b0000, flags {1,0,1,0}, with out_ready = 1.
  - Required: the next cycle shows out_valid = 1, out_result = 5'b10000, out_flags = 4'b1010. After the pop edge, op_count = 1 and sticky_o = 1.
- Backpressure and FIFO order:
  - Hold out_ready = 0 and push A = 3 then B = 7.
  - Required: in_ready = 0 after the second push, and a third in_valid is ignored.
  - Then raise out_ready. Required: out_result = 3, then 7, then out_valid = 0. op_count = 2.
- Simultaneous push and pop in ONE: stream 10 results back-to-back with out_ready = 1. Required: state stays ONE, in_ready stays 1, outputs appear in input order, op_count = 10.
- Sticky priority: assert sticky_clr in the same cycle as a push with in_ca = 1. Required: sticky_ca = 1. Assert sticky_clr alone on the next cycle. Required: sticky_ca = 0.
- Reset mid-operation and wrap:
  - With the buffer FULL, pulse rst_n = 0. Required: EMPTY, with no stale entry emitted afterwards.
  - Separately, perform 256 pops. Required: op_count = 0.
  - Pop together with count_clr. Required: op_count = 0.
